// File: rtl/memory_access_unit.sv
// Memory access unit: checks the region of a core load/store/fetch, drives one memory access, and returns the response.
// Optional feature macro: MAU_ALIGN_CHECK_EN (word-alignment check in CHECK).
module memory_access_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    WAIT_CYCLES  = 1,
    parameter logic [DATA_WIDTH-1:0] ROM_BASE     = 32'h00400000,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE     = 32'h10010000,
    parameter int                    MEMORY_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_fault
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    // Region bounds carry one extra bit so an end address past 2^DATA_WIDTH-1 cannot wrap.
    localparam logic [DATA_WIDTH:0] REGION_BYTES = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH:0] ROM_LO       = {1'b0, ROM_BASE};
    localparam logic [DATA_WIDTH:0] ROM_HI       = ROM_LO + REGION_BYTES;
    localparam logic [DATA_WIDTH:0] RAM_LO       = {1'b0, RAM_BASE};
    localparam logic [DATA_WIDTH:0] RAM_HI       = RAM_LO + REGION_BYTES;

    function automatic logic f_in_region(
        input logic [DATA_WIDTH-1:0] addr,
        input logic [DATA_WIDTH:0]   lo,
        input logic [DATA_WIDTH:0]   hi
    );
        logic [DATA_WIDTH:0] v_addr;
        v_addr      = {1'b0, addr};
        f_in_region = (v_addr >= lo) && (v_addr < hi);
    endfunction

    logic [1:0]            r_state;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wait_cnt;
    logic                  r_req_ready;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_enable;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_fault;

    logic [1:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_region_ok;
    logic                  w_align_ok;
    logic                  w_check_ok;
    logic                  w_access_done;

    assign w_accept      = req_valid & r_req_ready;
    assign w_access_done = (r_wait_cnt >= WAIT_LIM);

    // Region and alignment check on the latched request.
    always_comb begin
        w_region_ok = 1'b0;
        w_align_ok  = 1'b1;
        if (f_in_region(r_addr, RAM_LO, RAM_HI)) begin
            w_region_ok = 1'b1;
        end else if (f_in_region(r_addr, ROM_LO, ROM_HI) && !r_we) begin
            w_region_ok = 1'b1;
        end else begin
            w_region_ok = 1'b0;
        end
`ifdef MAU_ALIGN_CHECK_EN
        if (r_addr[1:0] != 2'b00) begin
            w_align_ok = 1'b0;
        end else begin
            w_align_ok = 1'b1;
        end
`else
        w_align_ok = 1'b1;
`endif
        w_check_ok = w_region_ok & w_align_ok;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_check_ok) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_ACCESS: begin
                if (w_access_done) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, request latches and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= {DATA_WIDTH{1'b0}};
            r_wdata      <= {DATA_WIDTH{1'b0}};
            r_wait_cnt   <= 4'd0;
            r_req_ready  <= 1'b1;
            r_mem_addr   <= {DATA_WIDTH{1'b0}};
            r_mem_wdata  <= {DATA_WIDTH{1'b0}};
            r_mem_enable <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= {DATA_WIDTH{1'b0}};
            r_rsp_fault  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_check_ok) begin
                        r_mem_addr   <= r_addr;
                        r_mem_wdata  <= r_wdata;
                        r_mem_enable <= r_we;
                        r_wait_cnt   <= 4'd0;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_fault <= 1'b1;
                        r_rsp_data  <= {DATA_WIDTH{1'b0}};
                    end
                end
                S_ACCESS: begin
                    // The write strobe only ever lives in the first access cycle.
                    r_mem_enable <= 1'b0;
                    if (w_access_done) begin
                        r_mem_addr  <= {DATA_WIDTH{1'b0}};
                        r_mem_wdata <= {DATA_WIDTH{1'b0}};
                        r_rsp_valid <= 1'b1;
                        r_rsp_fault <= 1'b0;
                        r_rsp_data  <= r_we ? {DATA_WIDTH{1'b0}} : mem_rdata;
                    end else if (r_wait_cnt < WAIT_LIM) begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_fault <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_mem_enable <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_enable = r_mem_enable;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_fault  = r_rsp_fault;

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of data and address.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra cycles the memory address is held before read data is sampled; legal range 0-15.
REQ-003 SHALL have parameter ROM_BASE, default 32'h00400000: start of the program region.
REQ-004 SHALL have parameter RAM_BASE, default 32'h10010000: start of the data region.
REQ-005 SHALL have parameter MEMORY_DEPTH, default 64: number of words in each region.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-009 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-010 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load or fetch.
REQ-011 SHALL have ports req_addr and req_wdata, inputs, DATA_WIDTH bits each: byte address and store data.
REQ-012 SHALL have ports mem_addr and mem_wdata, outputs, DATA_WIDTH bits each: byte address and store data driven to the memory system.
REQ-013 SHALL have port mem_enable, output, 1 bit: write enable to the memory system.
REQ-014 SHALL have port mem_rdata, input, DATA_WIDTH bits: combinational read data from the memory system.
REQ-015 SHALL have ports rsp_valid and rsp_ready, 1 bit each: rsp_valid is an output and rsp_ready an input.
REQ-016 SHALL have port rsp_data, output, DATA_WIDTH bits: load result, and 0 for stores.
REQ-017 SHALL have port rsp_fault, output, 1 bit: the access was rejected.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, CHECK, ACCESS, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid=1 and req_ready=1, and its we, addr and wdata are latched into internal registers.
REQ-020 SHALL move from IDLE to CHECK on accept and from CHECK to ACCESS on the next edge, or to RESP with fault=1 when the region check fails.
REQ-021 SHALL pass the region check when the address is in [ROM_BASE, ROM_BASE+4*MEMORY_DEPTH) and req_we=0, or in [RAM_BASE, RAM_BASE+4*MEMORY_DEPTH); any other address fails, including a store to the ROM region.
REQ-022 SHALL hold mem_addr and mem_wdata at the latched values for WAIT_CYCLES+1 cycles in ACCESS and drive 0 on them outside ACCESS.
REQ-023 SHALL pulse mem_enable for exactly one cycle, the first ACCESS cycle, for stores; it is never asserted for loads.
REQ-024 SHALL sample mem_rdata into rsp_data on the last ACCESS edge for loads and set rsp_data to 0 for stores, then enter RESP.
REQ-025 SHALL hold rsp_valid=1 with stable rsp_data and rsp_fault in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL give a load latency of WAIT_CYCLES+3 edges from accept to the first rsp_valid cycle when rsp_ready is held high.
REQ-027 SHALL return rsp_valid=1 together with rsp_ready=1 on the same edge as a new request is presented: only the response completes, and the request is accepted the following cycle from IDLE.
REQ-028 SHALL count with a 4-bit wait counter that saturates safely at WAIT_CYCLES; address arithmetic is unsigned, and region-end sums that would wrap are treated as exceeding 2^DATA_WIDTH-1.

Reset
REQ-029 SHALL, when reset=0, immediately force the FSM to IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, mem_enable=0 and rsp_data, mem_addr, mem_wdata and all latches to 0.
REQ-030 SHALL abandon an access if reset is asserted mid-access, issue no further mem_enable, and produce no response.

Configuration
REQ-031 SHALL use macro MAU_ALIGN_CHECK_EN: when defined, an address with req_addr[1:0]!=0 also fails the check in CHECK (fault=1, no memory access); when undefined, the low two bits pass through unchecked.

Verification
REQ-032 SHALL cover a load: WAIT_CYCLES=1, addr 0x00400004, mem_rdata=0x2402000A -> rsp_valid 4 edges after accept, rsp_data=0x2402000A, rsp_fault=0.
REQ-033 SHALL cover a store: addr 0x10010008, wdata 0xDEADBEEF -> mem_enable high exactly one cycle with mem_addr=0x10010008 and mem_wdata=0xDEADBEEF, rsp_data=0.
REQ-034 SHALL cover a store to ROM: addr 0x00400000 -> rsp_fault=1, mem_enable never asserted.
REQ-035 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
REQ-036 SHALL cover reset mid-access: reset pulsed during ACCESS -> outputs at reset values immediately, no rsp_valid afterward.
REQ-037 SHALL cover misalignment: addr 0x10010002 -> rsp_fault=1 with MAU_ALIGN_CHECK_EN defined, and a normal access without it.
